// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle bubble insertion and flush squash.
// Define HAZARD_DETECT_EN to build load-use detection, the id_stall hazard term and bubble_count.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_b5,
  input  logic            branch,
  input  logic            memread,
  input  logic            mem2reg,
  input  logic            memwrite,
  input  logic            alusrc,
  input  logic            regwrite,
  input  logic [1:0]      aluop,
  input  logic            flush,
  input  logic            ex_hold,
  output logic            ex_valid,
  output logic            ex_branch,
  output logic            ex_memread,
  output logic            ex_mem2reg,
  output logic            ex_memwrite,
  output logic            ex_alusrc,
  output logic            ex_regwrite,
  output logic [1:0]      ex_aluop,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_b5,
  output logic            id_stall,
  output logic [15:0]     bubble_count
);

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       memread;
    logic       mem2reg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  load_use;

  always_comb begin
    // NOTE: default assigned first so every path drives id_ctrl and no latch is inferred.
    id_ctrl = '0;
    if (id_valid) begin
      id_ctrl = '{valid: 1'b1, branch: branch, memread: memread, mem2reg: mem2reg,
                  memwrite: memwrite, alusrc: alusrc, regwrite: regwrite, aluop: aluop};
    end
  end

`ifdef HAZARD_DETECT_EN
  logic [15:0] count_q;

  assign load_use = ex_ctrl.valid & ex_ctrl.memread & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A flush or a hold suppresses the load-use bubble, so neither counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (!flush && !ex_hold && load_use && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign bubble_count = count_q;
`else
  assign load_use     = 1'b0;
  assign bubble_count = '0;
`endif

  assign id_stall = ex_hold | (load_use & ~flush);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      ex_ctrl      <= '0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7_b5 <= 1'b0;
    end else if (flush || !ex_hold) begin
      // Flush beats hold; bubbles still load data, only control is cleared.
      ex_ctrl      <= (flush || load_use) ? ctrl_t'('0) : id_ctrl;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7_b5 <= id_funct7_b5;
    end
  end

  assign ex_valid    = ex_ctrl.valid;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_mem2reg  = ex_ctrl.mem2reg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hold and reset-mid-stall sequences, random vs model.
module tb_id_ex_stage;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk, reset, id_valid, id_funct7_b5;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        branch, memread, mem2reg, memwrite, alusrc, regwrite, flush, ex_hold;
  logic [1:0]  aluop;
  logic        ex_valid, ex_branch, ex_memread, ex_mem2reg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7_b5, id_stall;
  logic [15:0] bubble_count;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .branch(branch), .memread(memread), .mem2reg(mem2reg),
    .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite), .aluop(aluop),
    .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_mem2reg(ex_mem2reg), .ex_memwrite(ex_memwrite),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_b5(ex_funct7_b5), .id_stall(id_stall), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, hold, vld, branch, memread, mem2reg, memwrite, alusrc, regwrite;
    logic [1:0]  aluop;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_stall, e_valid, e_memread, e_regwrite;
    logic [1:0]  e_aluop;
    logic [4:0]  e_rd;
    logic [31:0] e_d1;
    logic [15:0] e_cnt;
    logic        chk_data;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model state: expected EX contents, whether data fields are defined, bubble total.
  in_t         m;
  logic        known;
  int unsigned cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic in_t zero_in();
    in_t z;
    z.rst = 0; z.flush = 0; z.hold = 0; z.vld = 0; z.branch = 0; z.memread = 0;
    z.mem2reg = 0; z.memwrite = 0; z.alusrc = 0; z.regwrite = 0; z.aluop = 0;
    z.pc = 0; z.d1 = 0; z.d2 = 0; z.imm = 0; z.rs1 = 0; z.rs2 = 0; z.rd = 0; z.f3 = 0; z.f7 = 0;
    return z;
  endfunction

  function automatic in_t mk(input logic vld, input logic mr, input logic rw, input logic [1:0] op,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [31:0] d1);
    in_t x = zero_in();
    x.vld = vld; x.memread = mr; x.mem2reg = mr; x.alusrc = mr; x.regwrite = rw; x.aluop = op;
    x.rs1 = r1; x.rs2 = r2; x.rd = rd; x.d1 = d1; x.d2 = ~d1; x.pc = d1 + 32'd4;
    x.imm = {d1[15:0], 16'h0}; x.f3 = 3'b010;
    return x;
  endfunction

  function automatic vec_t row(input in_t i, input logic st, input logic v, input logic mr,
                               input logic rw, input logic [1:0] op, input logic [4:0] rd,
                               input logic [31:0] d1, input logic [15:0] c, input logic cd);
    vec_t r;
    r.i = i; r.e_stall = st; r.e_valid = v; r.e_memread = mr; r.e_regwrite = rw;
    r.e_aluop = op; r.e_rd = rd; r.e_d1 = d1; r.e_cnt = c; r.chk_data = cd;
    return r;
  endfunction

  task automatic drive(input in_t x);
    reset = x.rst; flush = x.flush; ex_hold = x.hold; id_valid = x.vld;
    branch = x.branch; memread = x.memread; mem2reg = x.mem2reg; memwrite = x.memwrite;
    alusrc = x.alusrc; regwrite = x.regwrite; aluop = x.aluop;
    id_pc = x.pc; id_rs1_data = x.d1; id_rs2_data = x.d2; id_imm = x.imm;
    id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd; id_funct3 = x.f3; id_funct7_b5 = x.f7;
  endtask

  function automatic in_t kill_ctrl(input in_t x);
    in_t y = x;
    y.vld = 0; y.branch = 0; y.memread = 0; y.mem2reg = 0; y.memwrite = 0;
    y.alusrc = 0; y.regwrite = 0; y.aluop = 2'b00;
    return y;
  endfunction

  function automatic logic model_lu(input in_t x);
    return HZ && m.vld && m.memread && (m.rd != 0) && x.vld && (m.rd == x.rs1 || m.rd == x.rs2);
  endfunction

  task automatic model_step(input in_t x);
    logic lu = model_lu(x);
    if (x.rst) begin
      m = zero_in(); known = 1; cnt = 0;
    end else if (x.flush || (!x.hold && lu)) begin
      m = kill_ctrl(x); known = 0;
      if (!x.flush && cnt < 65535) cnt = cnt + 1;
    end else if (!x.hold) begin
      m = x.vld ? x : kill_ctrl(x); known = 1;
    end
  endtask

  task automatic compare_model();
    check("rnd_valid", ex_valid, m.vld);
    check("rnd_branch", ex_branch, m.branch);
    check("rnd_memread", ex_memread, m.memread);
    check("rnd_mem2reg", ex_mem2reg, m.mem2reg);
    check("rnd_memwrite", ex_memwrite, m.memwrite);
    check("rnd_alusrc", ex_alusrc, m.alusrc);
    check("rnd_regwrite", ex_regwrite, m.regwrite);
    check("rnd_aluop", ex_aluop, m.aluop);
    check("rnd_count", bubble_count, cnt);
    if (known) begin
      check("rnd_pc", ex_pc, m.pc);
      check("rnd_rs1_data", ex_rs1_data, m.d1);
      check("rnd_rs2_data", ex_rs2_data, m.d2);
      check("rnd_imm", ex_imm, m.imm);
      check("rnd_rs1", ex_rs1, m.rs1);
      check("rnd_rs2", ex_rs2, m.rs2);
      check("rnd_rd", ex_rd, m.rd);
      check("rnd_funct3", ex_funct3, m.f3);
      check("rnd_funct7", ex_funct7_b5, m.f7);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  tbl[16];
    in_t   x;
    logic [15:0] c1, c2, c3;

    x = zero_in(); x.rst = 1;
    drive(x);
    @(posedge clk); #1;

    c1 = HZ ? 16'd1 : 16'd0;
    c2 = HZ ? 16'd2 : 16'd0;
    c3 = HZ ? 16'd3 : 16'd0;
    x = mk(1, 1, 1, 2'b11, 7, 7, 7, 32'hFFFF_FFFF);
    x.rst = 1; x.hold = 1; x.branch = 1; x.memwrite = 1; x.f7 = 1;
    tbl[0]  = row(x, 1, 0, 0, 0, 2'b00, 0, 32'h0, 0, 1);
    tbl[1]  = row(mk(1, 0, 1, 2'b10, 1, 2, 5, 32'h11), 0, 1, 0, 1, 2'b10, 5, 32'h11, 0, 1);
    tbl[2]  = row(mk(1, 1, 1, 2'b00, 5, 0, 7, 32'h100), 0, 1, 1, 1, 2'b00, 7, 32'h100, 0, 1);
    x = mk(1, 0, 1, 2'b10, 3, 7, 8, 32'h33);
    tbl[3]  = HZ ? row(x, 1, 0, 0, 0, 2'b00, 0, 32'h0, c1, 0)
                 : row(x, 0, 1, 0, 1, 2'b10, 8, 32'h33, 0, 1);
    tbl[4]  = row(x, 0, 1, 0, 1, 2'b10, 8, 32'h33, c1, 1);
    tbl[5]  = row(mk(1, 1, 1, 2'b00, 1, 2, 0, 32'h44), 0, 1, 1, 1, 2'b00, 0, 32'h44, c1, 1);
    tbl[6]  = row(mk(1, 0, 1, 2'b10, 0, 0, 9, 32'h55), 0, 1, 0, 1, 2'b10, 9, 32'h55, c1, 1);
    tbl[7]  = row(mk(1, 1, 1, 2'b00, 1, 2, 6, 32'h66), 0, 1, 1, 1, 2'b00, 6, 32'h66, c1, 1);
    x = mk(1, 0, 1, 2'b10, 6, 0, 10, 32'h77); x.flush = 1;
    tbl[8]  = row(x, 0, 0, 0, 0, 2'b00, 0, 32'h0, c1, 0);
    tbl[9]  = row(mk(0, 1, 1, 2'b11, 0, 0, 11, 32'h88), 0, 0, 0, 0, 2'b00, 11, 32'h88, c1, 1);
    tbl[10] = row(mk(1, 1, 1, 2'b00, 11, 0, 12, 32'h99), 0, 1, 1, 1, 2'b00, 12, 32'h99, c1, 1);
    x = mk(1, 1, 1, 2'b00, 12, 0, 12, 32'h9A);
    tbl[11] = HZ ? row(x, 1, 0, 0, 0, 2'b00, 0, 32'h0, c2, 0)
                 : row(x, 0, 1, 1, 1, 2'b00, 12, 32'h9A, 0, 1);
    tbl[12] = row(x, 0, 1, 1, 1, 2'b00, 12, 32'h9A, c2, 1);
    x = mk(1, 0, 1, 2'b10, 1, 12, 13, 32'hAA);
    tbl[13] = HZ ? row(x, 1, 0, 0, 0, 2'b00, 0, 32'h0, c3, 0)
                 : row(x, 0, 1, 0, 1, 2'b10, 13, 32'hAA, 0, 1);
    tbl[14] = row(x, 0, 1, 0, 1, 2'b10, 13, 32'hAA, c3, 1);
    x = mk(1, 0, 1, 2'b10, 13, 0, 14, 32'hBB); x.flush = 1; x.hold = 1;
    tbl[15] = row(x, 1, 0, 0, 0, 2'b00, 0, 32'h0, c3, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      @(negedge clk);
      check($sformatf("vec%0d_stall", k), id_stall, tbl[k].e_stall);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", k), ex_valid, tbl[k].e_valid);
      check($sformatf("vec%0d_memread", k), ex_memread, tbl[k].e_memread);
      check($sformatf("vec%0d_regwrite", k), ex_regwrite, tbl[k].e_regwrite);
      check($sformatf("vec%0d_aluop", k), ex_aluop, tbl[k].e_aluop);
      check($sformatf("vec%0d_count", k), bubble_count, tbl[k].e_cnt);
      if (!tbl[k].e_valid) begin
        check($sformatf("vec%0d_ctrl_zero", k),
              {ex_branch, ex_mem2reg, ex_memwrite, ex_alusrc}, 4'b0000);
      end
      if (tbl[k].chk_data) begin
        check($sformatf("vec%0d_rd", k), ex_rd, tbl[k].e_rd);
        check($sformatf("vec%0d_rs1_data", k), ex_rs1_data, tbl[k].e_d1);
      end
    end

    // Hold for three cycles with changing inputs, then release.
    drive(mk(1, 0, 1, 2'b10, 1, 2, 3, 32'h1234));
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      x = mk(1, 1, 0, 2'b01, 5'(k), 5'(k), 5'(20 + k), 32'(k + 5));
      x.hold = 1;
      drive(x);
      @(negedge clk);
      check("hold_stall", id_stall, 1'b1);
      @(posedge clk); #1;
      check("hold_rs1_data", ex_rs1_data, 32'h1234);
      check("hold_rd", ex_rd, 5'd3);
      check("hold_ctrl", {ex_valid, ex_memread, ex_regwrite, ex_aluop}, 5'b10110);
    end
    drive(mk(1, 0, 1, 2'b01, 4, 4, 25, 32'hBEEF));
    @(negedge clk);
    check("release_stall", id_stall, 1'b0);
    @(posedge clk); #1;
    check("release_rs1_data", ex_rs1_data, 32'hBEEF);
    check("release_rd", ex_rd, 5'd25);
    check("release_aluop", ex_aluop, 2'b01);

    // Reset arriving while a load-use stall is pending.
    drive(mk(1, 1, 1, 2'b00, 0, 0, 7, 32'h1));
    @(posedge clk); #1;
    x = mk(1, 0, 1, 2'b10, 7, 0, 8, 32'h2); x.rst = 1;
    drive(x);
    @(negedge clk);
    check("rststall_stall", id_stall, HZ);
    @(posedge clk); #1;
    check("rststall_valid", ex_valid, 1'b0);
    check("rststall_count", bubble_count, 16'd0);
    x.rst = 0;
    drive(x);
    @(negedge clk);
    check("rststall_after", id_stall, 1'b0);
    @(posedge clk); #1;
    check("rststall_load_valid", ex_valid, 1'b1);
    check("rststall_load_rd", ex_rd, 5'd8);

    // Randomized traffic against the reference model.
    x = zero_in(); x.rst = 1;
    drive(x);
    @(posedge clk); #1;
    model_step(x);
    for (int n = 0; n < 3000; n++) begin
      x = zero_in();
      x.rst = ($urandom_range(0, 199) == 0);
      x.flush = ($urandom_range(0, 9) == 0);
      x.hold = ($urandom_range(0, 7) == 0);
      x.vld = ($urandom_range(0, 5) != 0);
      x.branch = 1'($urandom); x.memread = ($urandom_range(0, 2) == 0);
      x.mem2reg = 1'($urandom); x.memwrite = 1'($urandom);
      x.alusrc = 1'($urandom); x.regwrite = 1'($urandom); x.aluop = 2'($urandom);
      x.pc = $urandom; x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom;
      x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
      x.rd = 5'($urandom_range(0, 3)); x.f3 = 3'($urandom); x.f7 = 1'($urandom);
      drive(x);
      @(negedge clk);
      check("rnd_stall", id_stall, x.hold || (model_lu(x) && !x.flush));
      @(posedge clk); #1;
      model_step(x);
      compare_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the RISC-V core. It sits directly downstream of the decode-stage control unit and register file, and latches their outputs into the execute stage: control bundle, operands, immediate, register indices and funct bits. It also detects load-use hazards, inserting a one-cycle bubble and stalling upstream, and it squashes its contents on a taken-branch flush.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register-index width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN  decode-stage values
- id_rs1, id_rs2, id_rd  in  RA_W  register indices
- id_funct3  in  3  instruction funct3
- id_funct7_b5  in  1  instruction bit 30
- branch, memread, mem2reg, memwrite, alusrc, regwrite  in  1 each  control unit outputs
- aluop  in  2  control unit ALU op class
- flush  in  1  taken branch resolved in EX; squash decode slot
- ex_hold  in  1  downstream stall; freeze this register
- ex_valid, ex_branch, ex_memread, ex_mem2reg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered
- ex_aluop  out  2  registered
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered
- ex_rs1, ex_rs2, ex_rd  out  RA_W  registered
- ex_funct3  out  3; ex_funct7_b5  out  1  registered
- id_stall  out  1  combinational; upstream holds PC and IF/ID when 1
- bubble_count  out  16  load-use bubbles inserted; saturating

## Operation
- load_use = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)). The check compares both sources conservatively, with no opcode qualification.
- id_stall = ex_hold | (load_use & ~flush).
- Each rising edge applies the first matching rule:
  1. reset: all ex_* = 0, bubble_count = 0.
  2. flush: bubble. ex_valid and all control outputs go to 0, ex_aluop = 00. Data fields are don't-care and are loaded from the inputs.
  3. ex_hold: every ex_* register keeps its value. bubble_count is unchanged.
  4. load_use: bubble, as in rule 2. bubble_count increments by 1 and saturates at 16'hFFFF.
  5. Otherwise, load all inputs. If id_valid = 0, all control outputs are forced to 0.
- Invariant: ex_valid = 0 implies every ex control bit is 0 and ex_aluop = 00. EX/MEM relies on this and does not gate on valid.
- Only one bubble is needed per load. The load leaves EX on the next edge, so load_use deasserts and MEM/WB forwarding supplies the data.
- Reset mid-stall: the registers clear and load_use becomes 0 on the following cycle. id_stall then follows ex_hold only.

## Timing
- Latency: 1 cycle from decode inputs to ex_* outputs.
- id_stall is purely combinational from the current ex_* registers and the id_* and flush/ex_hold inputs. It has no registered delay and no dependency on reset in the same cycle.
- The flush and load_use bubbles each take exactly one cycle. Back-to-back loads to the same rd stall once each.
- Simultaneous flush and load_use: flush wins, id_stall = ex_hold, and bubble_count does not increment.
- Simultaneous flush and ex_hold: flush wins and the register is bubbled. EX/MEM guarantees this case only arises when the EX instruction is being retired.
- bubble_count wraps never; it holds at 16'hFFFF.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection, bubble insertion, the id_stall contribution and bubble_count are implemented as described above.
- Not defined: load_use is tied to 0, id_stall = ex_hold, and bubble_count is tied to 0. Software or the compiler must schedule load delay slots.

## Test plan
- Reset: assert reset with all inputs nonzero -> after the edge every ex_* = 0, bubble_count = 0, and id_stall = ex_hold.
- R-type pass-through: id_valid=1, regwrite=1, aluop=10, rs1_data=32'h11, rs2_data=32'h22, rd=5 -> next cycle ex_regwrite=1, ex_aluop=10, ex_rs1_data=32'h11, ex_rd=5, with id_stall=0 throughout.
- Load-use: lw x7 in EX (ex_memread=1, ex_rd=7) and add with id_rs2=7 -> id_stall=1 that cycle. Next edge: ex_valid=0, bubble_count=1. The following cycle id_stall=0 and the add loads.
- x0 exemption: lw x0 in EX with id_rs1=0 -> id_stall=0 and no bubble.
- Flush priority: load_use and flush both active -> ex_valid=0, id_stall=0, bubble_count unchanged.
- Hold: ex_hold=1 for 3 cycles with inputs changing -> ex_* stays constant and id_stall=1. When hold drops, the current inputs load on the next edge.
